// File: rtl/viewport_normalizer_if.sv
// Vertex-in / pixel-out handshake bundle for the viewport normalizer.
// Latency: none (wires only).
// Backpressure: valid/ready on both channels; the source holds its data while valid is high and ready is low.
interface viewport_normalizer_if #(
   parameter int CORDW = 16,
   parameter int PIXW  = 10
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [CORDW-1:0] in_x;
   logic signed [CORDW-1:0] in_y;
   logic signed [CORDW-1:0] in_z;
   logic signed [CORDW-1:0] in_w;
   logic                    out_valid;
   logic                    out_ready;
   logic [PIXW-1:0]         out_pixel_x;
   logic [PIXW-1:0]         out_pixel_y;
   logic                    out_clip;

   // Vertex source / pixel sink side (transform stage and rasteriser)
   modport master (
      output in_valid, in_x, in_y, in_z, in_w, out_ready,
      input  in_ready, out_valid, out_pixel_x, out_pixel_y, out_clip
   );

   // Normalizer side
   modport slave (
      input  in_valid, in_x, in_y, in_z, in_w, out_ready,
      output in_ready, out_valid, out_pixel_x, out_pixel_y, out_clip
   );
endinterface

// File: rtl/viewport_normalizer.sv
// Perspective divide + viewport mapping of one homogeneous vertex to clamped screen pixels, with frustum clip reject.
// Latency: 2*(CORDW+SCALEW)+1 cycles from input handshake to out_valid; clipped vertices take 1 cycle.
// Backpressure: one vertex in flight; in_ready is high only when idle, results are held in DONE until out_ready.
module viewport_normalizer #(
   parameter int CORDW    = 16,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int SCALEW   = 9,
   parameter int PIXW     = 10
) (
   input logic              clock,
   input logic              reset,
   viewport_normalizer_if.slave bus
);

   localparam int HW = SCREEN_W / 2;
   localparam int HH = SCREEN_H / 2;
   localparam int NW = CORDW + SCALEW;
   localparam int RW = CORDW + 1;
   localparam int CW = $clog2(NW + 1);

   localparam logic [NW-1:0]        HW_N   = NW'(HW);
   localparam logic [NW-1:0]        HH_N   = NW'(HH);
   localparam logic signed [NW+1:0] HW_S   = (NW+2)'(HW);
   localparam logic signed [NW+1:0] HH_S   = (NW+2)'(HH);
   localparam logic signed [NW+1:0] XMAX_S = (NW+2)'(SCREEN_W - 1);
   localparam logic signed [NW+1:0] YMAX_S = (NW+2)'(SCREEN_H - 1);
   localparam logic [CW-1:0]        CNT_X_LAST = CW'(NW);
   localparam logic [CW-1:0]        CNT_Y_LAST = CW'(NW - 1);

   typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

   state_t state, state_nx;

   logic [NW-1:0]    dvd;       // dividend, shifts left; quotient bits fill from the bottom
   logic [CORDW-1:0] rem;
   logic [NW-1:0]    y_dvd;     // |y|*HH parked until the x divide finishes
   logic [NW-1:0]    qx;
   logic [CORDW-1:0] w_r;
   logic             x_neg;
   logic             y_neg;
   logic             clip_r;
   logic [CW-1:0]    cnt;
   logic [PIXW-1:0]  pix_x_r;
   logic [PIXW-1:0]  pix_y_r;
   logic             clip_out_r;

   // Magnitude in CORDW+1 bits so the most negative input stays exact
   function automatic logic [RW-1:0] mag(input logic [CORDW-1:0] v);
      logic [RW-1:0] s;
      s = {v[CORDW-1], v};
      return v[CORDW-1] ? (~s + RW'(1)) : s;
   endfunction

   function automatic logic [PIXW-1:0] clamp(input logic signed [NW+1:0] v,
                                             input logic signed [NW+1:0] maxv);
      if (v < 0)
         return '0;
      else if (v > maxv)
         return maxv[PIXW-1:0];
      else
         return v[PIXW-1:0];
   endfunction

   logic [RW-1:0] xm, ym, zm, w_ext_in;
   logic          clip_in;

   // Frustum test on the incoming vertex
   always_comb begin
      xm       = mag(bus.in_x);
      ym       = mag(bus.in_y);
      zm       = mag(bus.in_z);
      w_ext_in = {1'b0, bus.in_w};
      clip_in  = bus.in_w[CORDW-1] | (bus.in_w == '0) |
                 (xm > w_ext_in) | (ym > w_ext_in) | (zm > w_ext_in);
   end

   logic [RW-1:0]       rem_sh;
   logic                ge;
   logic [CORDW-1:0]    rem_nx;
   logic [NW-1:0]       dvd_nx;
   logic signed [NW+1:0] px_s, py_s;

   // One restoring-divide step and the pixel mapping of the finished quotients
   always_comb begin
      rem_sh = {rem, dvd[NW-1]};
      ge     = rem_sh >= {1'b0, w_r};
      rem_nx = ge ? (rem_sh[CORDW-1:0] - w_r) : rem_sh[CORDW-1:0];
      dvd_nx = {dvd[NW-2:0], ge};
      px_s   = x_neg ? (HW_S - $signed({2'b00, qx}))     : (HW_S + $signed({2'b00, qx}));
      py_s   = y_neg ? (HH_S + $signed({2'b00, dvd_nx})) : (HH_S - $signed({2'b00, dvd_nx}));
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next state: first DIV_X cycle resolves the clip reject, then NW steps for x and NW for y
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nx = DIV_X;
         DIV_X:   begin
                     if (cnt == '0 && clip_r)   state_nx = DONE;
                     else if (cnt == CNT_X_LAST) state_nx = DIV_Y;
                  end
         DIV_Y:   if (cnt == CNT_Y_LAST) state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture, divider iteration and result registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dvd        <= '0;
         rem        <= '0;
         y_dvd      <= '0;
         qx         <= '0;
         w_r        <= '0;
         x_neg      <= 1'b0;
         y_neg      <= 1'b0;
         clip_r     <= 1'b0;
         cnt        <= '0;
         pix_x_r    <= '0;
         pix_y_r    <= '0;
         clip_out_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  dvd    <= NW'(xm) * HW_N;
                  y_dvd  <= NW'(ym) * HH_N;
                  w_r    <= bus.in_w;
                  x_neg  <= bus.in_x[CORDW-1];
                  y_neg  <= bus.in_y[CORDW-1];
                  clip_r <= clip_in;
                  rem    <= '0;
                  cnt    <= '0;
               end
            end
            DIV_X: begin
               if (cnt == '0) begin
                  cnt <= CW'(1);
                  if (clip_r) begin
                     pix_x_r    <= '0;
                     pix_y_r    <= '0;
                     clip_out_r <= 1'b1;
                  end
               end else if (cnt == CNT_X_LAST) begin
                  qx  <= dvd_nx;
                  dvd <= y_dvd;
                  rem <= '0;
                  cnt <= '0;
               end else begin
                  dvd <= dvd_nx;
                  rem <= rem_nx;
                  cnt <= cnt + CW'(1);
               end
            end
            DIV_Y: begin
               dvd <= dvd_nx;
               rem <= rem_nx;
               cnt <= cnt + CW'(1);
               if (cnt == CNT_Y_LAST) begin
                  pix_x_r    <= clamp(px_s, XMAX_S);
                  pix_y_r    <= clamp(py_s, YMAX_S);
                  clip_out_r <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready    = (state == IDLE);
   assign bus.out_valid   = (state == DONE);
   assign bus.out_pixel_x = pix_x_r;
   assign bus.out_pixel_y = pix_y_r;
   assign bus.out_clip    = clip_out_r;

endmodule
